fp_pipe_ctrl: RTL and testbench
===============================

FP_PIPE_CTRL -- requirements
Module: fp_pipe_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 wf  input  1  ID issues an FPU op that writes an FPR; already gated by the decoder's pipeline-enable.
REQ-004 fd  input  5  FPR destination of the ID op.
REQ-005 fc  input  3  FPU op code from ID: 000 fadd, 001 fsub, 010 fmul, 100 fdiv, 101 fsqrt.
REQ-006 e1w/e1n/e1c  output  1/5/3  E1 stage write-enable, destination, op code.
REQ-007 e2w/e2n  output  1/5  E2 stage write-enable, destination.
REQ-008 e3w/e3n  output  1/5  E3 stage write-enable, destination.
REQ-009 wwf/wwn  output  1/5  WB stage FPR write-enable, destination.
REQ-010 stall_div_sqrt  output  1  E1 is busy with an iterative fdiv/fsqrt; the decoder freezes PC/IR.

Function
REQ-011 Parameter DS_CYC (default 8, legal range 2..31): number of cycles stall_div_sqrt stays high per fdiv/fsqrt.
REQ-012 Pipeline (E1->E2->E3->WB) is a register chain; with stall_div_sqrt low, each edge does E1<={wf,fd,fc}, E2<=E1, E3<=E2, WB<=E3.
REQ-013 FSM states: IDLE, ITER; 5-bit down-counter cnt.
REQ-014 IDLE->ITER on an edge loading E1 with wf=1 and fc in {100,101}; cnt<=DS_CYC-1 on the same edge.
REQ-015 In ITER: stall_div_sqrt=1 (decoded from state only, no input path); E1 holds; E2 loads a bubble (e2w=0, e2n=0); E3 and WB advance; wf/fd/fc are ignored.
REQ-016 In ITER with cnt!=0: cnt decrements. With cnt==0: next state IDLE.
REQ-017 The edge leaving ITER does not shift E1. The following edge moves the div/sqrt op to E2 and samples ID normally.
REQ-018 A div/sqrt issued in the cycle its predecessor leaves E1 re-triggers ITER. No idle gap between back-to-back div/sqrt.
REQ-019 wf=0 loads a bubble regardless of fd/fc. fc codes 011, 110 and 111 behave as single-pass ops (no stall).
REQ-020 A div/sqrt in E1 with wf=0 never triggers ITER.
REQ-021 Each stage's n field is forced to 0 whenever its w bit is 0.

Reset
REQ-022 rst clears every stage (w=0, n=0, e1c=000), state=IDLE, cnt=0, stall_div_sqrt=0, immediately and asynchronously.
REQ-023 rst asserted mid-ITER abandons the op; it never reaches WB.

Configuration
REQ-024 Macro FPU_DIVSQRT_EN defined: iterative behaviour per REQ-013..018.
REQ-025 Macro FPU_DIVSQRT_EN undefined: no FSM or counter is built; stall_div_sqrt is constant 0; fdiv/fsqrt flow through like fadd.

Structure
REQ-026 Shared package fpu_pkg holds the fc encodings (FC_ADD, FC_SUB, FC_MUL, FC_DIV, FC_SQRT), the FSM state enum, and the DS_CYC default.
REQ-027 One sub-module fp_stage_reg (enable, bubble-insert, w/n/c register with async clear) is instantiated per stage.

Verification
REQ-028 Scenario 1: fadd f3 issued at cycle 0 -> e1w/e1n=1/3 at cycle 1, e2 at cycle 2, e3 at cycle 3, wwf/wwn=1/3 at cycle 4; stall_div_sqrt stays 0.
REQ-029 Scenario 2: fdiv f5 at cycle 0 with DS_CYC=8 -> stall_div_sqrt high cycles 1..8; e1n=5 held cycles 1..9; e2w=0 cycles 2..9; e2n=5 at cycle 10; wwn=5 at cycle 12.
REQ-030 Scenario 3: fdiv f1 then fsqrt f2 back-to-back -> two stall windows of 8 cycles each, separated by exactly one non-stall cycle; WB order f1 then f2.
REQ-031 Scenario 4: fmul f7 at cycle 0, fdiv f4 at cycle 1 -> f7 reaches E2, E3 and WB on schedule while f4 stalls in E1; wwn=7 at cycle 4.
REQ-032 Scenario 5: rst pulsed at cycle 4 of an fdiv stall -> all outputs 0 within the same cycle; no WB write for that op; a later fadd f9 behaves as in Scenario 1.
REQ-033 Scenario 6: build without FPU_DIVSQRT_EN, fdiv f6 at cycle 0 -> stall_div_sqrt never 1; wwn=6 at cycle 4.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU pipeline-control definitions: op-code encodings, div/sqrt FSM
// states, default iteration length and the per-stage record.
package fpu_pkg;

  localparam logic [2:0] FC_ADD  = 3'b000;
  localparam logic [2:0] FC_SUB  = 3'b001;
  localparam logic [2:0] FC_MUL  = 3'b010;
  localparam logic [2:0] FC_DIV  = 3'b100;
  localparam logic [2:0] FC_SQRT = 3'b101;

  localparam int DS_CYC_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } ds_state_e;

  typedef struct packed {
    logic       w;
    logic [4:0] n;
    logic [2:0] c;
  } fp_stage_t;

  function automatic logic is_divsqrt(input logic [2:0] fc);
    return (fc == FC_DIV) || (fc == FC_SQRT);
  endfunction

endpackage

// File: rtl/fp_stage_reg.sv
// One pipeline stage register: hold when disabled, optional bubble insert,
// and an empty record whenever the incoming op does not write.
module fp_stage_reg
  import fpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en_i,
  input  logic      bub_i,
  input  fp_stage_t d_i,
  output fp_stage_t q_o
);

  fp_stage_t q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en_i) begin
      if (bub_i || !d_i.w) q_q <= '0;
      else                 q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fp_pipe_ctrl.sv
// FPU E1->E2->E3->WB control pipeline. Define FPU_DIVSQRT_EN to build the
// iterative fdiv/fsqrt stall FSM; otherwise every op is single-pass.
module fp_pipe_ctrl
  import fpu_pkg::*;
#(
  parameter int DS_CYC = DS_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wf,
  input  logic [4:0] fd,
  input  logic [2:0] fc,
  output logic       e1w,
  output logic [4:0] e1n,
  output logic [2:0] e1c,
  output logic       e2w,
  output logic [4:0] e2n,
  output logic       e3w,
  output logic [4:0] e3n,
  output logic       wwf,
  output logic [4:0] wwn,
  output logic       stall_div_sqrt
);

  fp_stage_t id_s, e1_s, e2_s, e3_s, wb_s;
  logic      stall;

  assign id_s = '{w: wf, n: fd, c: fc};

  // E1 freezes on the iterating op while E2 takes bubbles behind it.
  fp_stage_reg u_e1 (.clk(clk), .rst(rst), .en_i(!stall), .bub_i(1'b0),  .d_i(id_s), .q_o(e1_s));
  fp_stage_reg u_e2 (.clk(clk), .rst(rst), .en_i(1'b1),   .bub_i(stall), .d_i(e1_s), .q_o(e2_s));
  fp_stage_reg u_e3 (.clk(clk), .rst(rst), .en_i(1'b1),   .bub_i(1'b0),  .d_i(e2_s), .q_o(e3_s));
  fp_stage_reg u_wb (.clk(clk), .rst(rst), .en_i(1'b1),   .bub_i(1'b0),  .d_i(e3_s), .q_o(wb_s));

`ifdef FPU_DIVSQRT_EN
  ds_state_e  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Triggers on the ID op being latched into E1, so a div/sqrt queued behind
  // another one re-enters ITER without an idle gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (wf && is_divsqrt(fc)) begin
        state_d = ST_ITER;
        cnt_d   = 5'(DS_CYC - 1);
      end
      ST_ITER: if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
               else               state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall = (state_q == ST_ITER);
`else
  localparam int unused_ds_cyc = DS_CYC;
  assign stall = 1'b0;
`endif

  logic unused_wb_c;
  assign unused_wb_c = ^wb_s.c;

  assign e1w = e1_s.w;
  assign e1n = e1_s.n;
  assign e1c = e1_s.c;
  assign e2w = e2_s.w;
  assign e2n = e2_s.n;
  assign e3w = e3_s.w;
  assign e3n = e3_s.n;
  assign wwf = wb_s.w;
  assign wwn = wb_s.n;
  assign stall_div_sqrt = stall;

endmodule

// File: tb/tb_fp_pipe_ctrl.sv
// Scoreboard bench for fp_pipe_ctrl; the model schedules each accepted op
// by cycle number and the monitor checks the pipeline every cycle.
module tb_fp_pipe_ctrl;

  localparam int DS = 8;
`ifdef FPU_DIVSQRT_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif
  localparam int N = 4096;

  typedef struct packed {
    logic       w;
    logic [4:0] n;
    logic [2:0] c;
  } ent_t;

  typedef struct {
    logic [4:0] n;
    int         cyc;
  } wb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wf = 1'b0;
  logic [4:0] fd = '0;
  logic [2:0] fc = '0;
  logic       e1w, e2w, e3w, wwf, stall_div_sqrt;
  logic [4:0] e1n, e2n, e3n, wwn;
  logic [2:0] e1c;

  fp_pipe_ctrl #(.DS_CYC(DS)) dut (
    .clk(clk), .rst(rst), .wf(wf), .fd(fd), .fc(fc),
    .e1w(e1w), .e1n(e1n), .e1c(e1c),
    .e2w(e2w), .e2n(e2n), .e3w(e3w), .e3n(e3n),
    .wwf(wwf), .wwn(wwn), .stall_div_sqrt(stall_div_sqrt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   run = 1'b0;
  ent_t ex1 [N];
  ent_t ex2 [N];
  ent_t ex3 [N];
  bit   exs [N];
  wb_t  sbq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: per-cycle stage checks plus in-order WB scoreboard.
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("stall", 32'(stall_div_sqrt), 32'(exs[cyc]));
      chk("e1", 32'({e1w, e1n, e1c}), 32'(ex1[cyc]));
      chk("e2", 32'({e2w, e2n}), 32'({ex2[cyc].w, ex2[cyc].n}));
      chk("e3", 32'({e3w, e3n}), 32'({ex3[cyc].w, ex3[cyc].n}));
      if (wwf) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL wb_unexpected cyc=%0d got wwn=%0d exp no write", cyc, wwn);
        end else begin
          wb_t e;
          e = sbq.pop_front();
          chk("wb_n", 32'(wwn), 32'(e.n));
          chk("wb_cyc", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("wb_idle_n", 32'(wwn), 32'd0);
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          n_vec++;
          n_err++;
          $display("FAIL wb_missing cyc=%0d got no write exp wwn=%0d", cyc, sbq[0].n);
          void'(sbq.pop_front());
        end
      end
    end
  end

  // Op latched into E1 at the end of cycle t: single-pass ops reach WB at
  // t+4, div/sqrt spend DS extra cycles in E1 and stall t+1..t+DS.
  task automatic accept_op(input int t, input logic w, input logic [4:0] n, input logic [2:0] c);
    bit ds;
    int d;
    ds = w && DS_EN && (c == 3'b100 || c == 3'b101);
    d  = ds ? DS : 0;
    ex1[t+1] = w ? {1'b1, n, c} : '0;
    if (w) begin
      ex2[t+2+d] = {1'b1, n, 3'b000};
      ex3[t+3+d] = {1'b1, n, 3'b000};
      sbq.push_back('{n, t + 4 + d});
    end
    if (ds) for (int k = 1; k <= DS; k++) exs[t+k] = 1'b1;
  endtask

  task automatic step(input logic w, input logic [4:0] n, input logic [2:0] c,
                      input bit junk, output bit acc);
    @(posedge clk); #1;
    if (exs[cyc]) begin
      ex1[cyc+1] = ex1[cyc];
      if (junk) begin
        wf = 1'($urandom);
        fd = 5'($urandom);
        fc = 3'($urandom);
      end else begin
        wf = w; fd = n; fc = c;
      end
      acc = 1'b0;
    end else begin
      wf = w; fd = n; fc = c;
      accept_op(cyc, w, n, c);
      acc = 1'b1;
    end
  endtask

  task automatic issue(input logic w, input logic [4:0] n, input logic [2:0] c, input bit junk);
    bit acc;
    acc = 1'b0;
    while (!acc) step(w, n, c, junk, acc);
  endtask

  task automatic idle(input int k);
    bit acc;
    for (int i = 0; i < k; i++) step(1'b0, 5'd0, 3'd0, 1'b0, acc);
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    wf = 1'b0; fd = '0; fc = '0;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'({e1w, e1n, e1c, e2w, e2n, e3w, e3n, wwf, wwn, stall_div_sqrt}), 32'd0);
    #1 rst = 1'b0;
    for (int k = cyc; k < N; k++) begin
      ex1[k] = '0; ex2[k] = '0; ex3[k] = '0; exs[k] = 1'b0;
    end
    sbq.delete();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      ex1[k] = '0; ex2[k] = '0; ex3[k] = '0; exs[k] = 1'b0;
    end
    #1;
    chk("rst_state", 32'({e1w, e1n, e1c, e2w, e2n, e3w, e3n, wwf, wwn, stall_div_sqrt}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;
    idle(2);

    issue(1'b1, 5'd3, 3'b000, 1'b0);          // fadd f3
    idle(6);
    issue(1'b1, 5'd5, 3'b100, 1'b0);          // fdiv f5
    idle(14);
    issue(1'b1, 5'd1, 3'b100, 1'b0);          // fdiv f1 then fsqrt f2
    issue(1'b1, 5'd2, 3'b101, 1'b0);
    idle(14);
    issue(1'b1, 5'd7, 3'b010, 1'b0);          // fmul f7 then fdiv f4
    issue(1'b1, 5'd4, 3'b100, 1'b0);
    idle(14);
    issue(1'b0, 5'd11, 3'b100, 1'b0);         // div code without wf
    issue(1'b1, 5'd12, 3'b111, 1'b0);         // unused code, single pass
    idle(6);
    issue(1'b1, 5'd8, 3'b100, 1'b0);          // fdiv f8 killed by reset
    idle(3);
    mid_reset();
    idle(2);
    issue(1'b1, 5'd9, 3'b000, 1'b0);          // fadd f9
    idle(6);

    for (int i = 0; i < 200; i++) begin
      logic       w;
      logic [4:0] n;
      logic [2:0] c;
      int         r;
      w = ($urandom_range(0, 3) != 0);
      n = 5'($urandom);
      r = $urandom_range(0, 9);
      c = (r < 2) ? 3'b100 : (r < 4) ? 3'b101 : 3'($urandom_range(0, 7));
      issue(w, n, c, 1'b1);
    end
    idle(DS + 10);

    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL wb_drain got %0d pending exp 0", sbq.size());
    end
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
